// File: rtl/cv_sp_pkg.sv
// Shared sprite-attribute definitions: posy field placement, sprite height and
// the scanline hit test used by both the search and render blocks.
package cv_sp_pkg;

    localparam int unsigned SP_VCNT_W      = 10;
    localparam int unsigned SP_IDX_W       = 10;
    localparam int unsigned SP_CNT_W       = 11;
    localparam int unsigned SP_ATTR_W      = 64;
    localparam int unsigned SP_POSY_LSB    = 0;
    localparam int unsigned SP_POSY_W      = 11;
    localparam int unsigned SP_HEIGHT_LOG2 = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sp_state_e;

    // Line is inside the sprite when (line - posy) mod 2^11 < sprite height;
    // the modulo lets a sprite starting near 2047 wrap onto the top lines.
    function automatic logic sp_line_hit(input logic [SP_VCNT_W-1:0] line,
                                         input logic [SP_POSY_W-1:0] posy);
        logic [SP_POSY_W-1:0] diff;
        diff = SP_POSY_W'(line) - posy;
        return diff[SP_POSY_W-1:SP_HEIGHT_LOG2] == '0;
    endfunction

endpackage

// File: rtl/cv_sp_search.sv
// Per-scanline sprite search: scans the attribute RAM and writes the indices of
// sprites covering v_count into the search list RAM, in ascending index order.
module cv_sp_search
    import cv_sp_pkg::*;
#(
    parameter int unsigned SP_NUM  = 1024,
    parameter int unsigned MAX_HIT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs,
    input  logic [SP_VCNT_W-1:0] v_count,
    output logic                 search_end,
    output logic [SP_CNT_W-1:0]  search_count,
    output logic                 overflow,
    output logic [SP_IDX_W-1:0]  p_addr,
    output logic                 p_ren,
    input  logic [SP_ATTR_W-1:0] p_data,
    output logic [SP_IDX_W-1:0]  sch_waddr,
    output logic                 sch_wen,
    output logic [SP_IDX_W-1:0]  sch_wdata
);

    localparam logic [SP_IDX_W-1:0] LAST_IDX = SP_IDX_W'(SP_NUM - 1);
    localparam logic [SP_CNT_W-1:0] HIT_LIM  = SP_CNT_W'(MAX_HIT);

    sp_state_e             state_q, state_d;
    logic                  p_ren_q, p_ren_d;
    logic [SP_IDX_W-1:0]   p_addr_q, p_addr_d;
    logic                  cmp_vld_q, cmp_vld_d;
    logic [SP_IDX_W-1:0]   cmp_idx_q, cmp_idx_d;
    logic [SP_CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  sch_wen_q, sch_wen_d;
    logic [SP_IDX_W-1:0]   sch_waddr_q, sch_waddr_d;
    logic [SP_IDX_W-1:0]   sch_wdata_q, sch_wdata_d;
    logic                  search_end_q, search_end_d;
    logic                  hit_c;
    logic [SP_POSY_W-1:0]  posy_c;
    logic                  unused_attr;

    assign posy_c      = p_data[SP_POSY_LSB +: SP_POSY_W];
    assign unused_attr = ^p_data[SP_ATTR_W-1:SP_POSY_W];

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            p_ren_q      <= 1'b0;
            p_addr_q     <= '0;
            cmp_vld_q    <= 1'b0;
            cmp_idx_q    <= '0;
            hit_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            sch_wen_q    <= 1'b0;
            sch_waddr_q  <= '0;
            sch_wdata_q  <= '0;
            search_end_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_ren_q      <= p_ren_d;
            p_addr_q     <= p_addr_d;
            cmp_vld_q    <= cmp_vld_d;
            cmp_idx_q    <= cmp_idx_d;
            hit_cnt_q    <= hit_cnt_d;
            ovf_q        <= ovf_d;
            sch_wen_q    <= sch_wen_d;
            sch_waddr_q  <= sch_waddr_d;
            sch_wdata_q  <= sch_wdata_d;
            search_end_q <= search_end_d;
        end
    end

    // Next state; compare stage uses the index issued one cycle earlier
    always_comb begin
        state_d      = state_q;
        p_ren_d      = 1'b0;
        p_addr_d     = p_addr_q;
        cmp_vld_d    = p_ren_q & cs;
        cmp_idx_d    = p_addr_q;
        hit_cnt_d    = hit_cnt_q;
        ovf_d        = ovf_q;
        sch_wen_d    = 1'b0;
        sch_waddr_d  = sch_waddr_q;
        sch_wdata_d  = sch_wdata_q;
        search_end_d = 1'b0;
        hit_c        = cs & cmp_vld_q & sp_line_hit(v_count, posy_c);

        case (state_q)
            ST_IDLE: begin
                if (cs) begin
                    state_d   = ST_SCAN;
                    p_ren_d   = 1'b1;
                    p_addr_d  = '0;
                    hit_cnt_d = '0;
                    ovf_d     = 1'b0;
                end
            end
            ST_SCAN: begin
                if (p_addr_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end else begin
                    p_ren_d  = 1'b1;
                    p_addr_d = p_addr_q + SP_IDX_W'(1);
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  search_end_d = 1'b1;
            default:  state_d = ST_IDLE;
        endcase

        // Full list saturates the count and flags overflow instead of writing
        if (hit_c) begin
            if (hit_cnt_q < HIT_LIM) begin
                sch_wen_d   = 1'b1;
                sch_waddr_d = hit_cnt_q[SP_IDX_W-1:0];
                sch_wdata_d = cmp_idx_q;
                hit_cnt_d   = hit_cnt_q + SP_CNT_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (!cs) begin
            state_d      = ST_IDLE;
            p_ren_d      = 1'b0;
            search_end_d = 1'b0;
        end
    end

    assign search_end   = search_end_q;
    assign search_count = hit_cnt_q;
    assign overflow     = ovf_q;
    assign p_addr       = p_addr_q;
    assign p_ren        = p_ren_q;
    assign sch_waddr    = sch_waddr_q;
    assign sch_wen      = sch_wen_q;
    assign sch_wdata    = sch_wdata_q;

endmodule

// File: tb/tb_cv_sp_search.sv
// Bench for cv_sp_search: two instances (large and tiny hit list) share stimulus
// and are checked against a plain-arithmetic reference of the sprite search.
module tb_cv_sp_search;

    localparam int SP_N = 8;

    logic        clk;
    logic        reset;
    logic        cs;
    logic [9:0]  v_count;

    logic        search_end_w   [2];
    logic [10:0] search_count_w [2];
    logic        overflow_w     [2];
    logic [9:0]  p_addr_w       [2];
    logic        p_ren_w        [2];
    logic [63:0] p_data_w       [2];
    logic [9:0]  sch_waddr_w    [2];
    logic        sch_wen_w      [2];
    logic [9:0]  sch_wdata_w    [2];

    logic [63:0] mem [1024];
    int          posy_tab [SP_N];

    int n_chk;
    int n_err;
    int nw [2];
    int late;
    int exp_idx [$];

    cv_sp_search #(.SP_NUM(SP_N), .MAX_HIT(8)) u_dut_a (
        .clk(clk), .reset(reset), .cs(cs), .v_count(v_count),
        .search_end(search_end_w[0]), .search_count(search_count_w[0]),
        .overflow(overflow_w[0]), .p_addr(p_addr_w[0]), .p_ren(p_ren_w[0]),
        .p_data(p_data_w[0]), .sch_waddr(sch_waddr_w[0]), .sch_wen(sch_wen_w[0]),
        .sch_wdata(sch_wdata_w[0])
    );

    cv_sp_search #(.SP_NUM(SP_N), .MAX_HIT(2)) u_dut_b (
        .clk(clk), .reset(reset), .cs(cs), .v_count(v_count),
        .search_end(search_end_w[1]), .search_count(search_count_w[1]),
        .overflow(overflow_w[1]), .p_addr(p_addr_w[1]), .p_ren(p_ren_w[1]),
        .p_data(p_data_w[1]), .sch_waddr(sch_waddr_w[1]), .sch_wen(sch_wen_w[1]),
        .sch_wdata(sch_wdata_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency attribute RAM per instance
    always @(posedge clk) begin
        if (p_ren_w[0]) p_data_w[0] <= mem[p_addr_w[0]];
        if (p_ren_w[1]) p_data_w[1] <= mem[p_addr_w[1]];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int max_hit(input int k);
        return (k == 0) ? 8 : 2;
    endfunction

    function automatic bit ref_hit(input int v, input int p);
        return ((v - p + 4096) % 2048) < 16;
    endfunction

    task automatic load_tab();
        for (int i = 0; i < SP_N; i++)
            mem[i] = {$urandom(), 21'($urandom()), 11'(posy_tab[i])};
    endtask

    task automatic sample_writes(input int c, input int drop);
        for (int k = 0; k < 2; k++) begin
            if (sch_wen_w[k]) begin
                if (drop >= 0 && c > drop) late++;
                chk($sformatf("waddr%0d", k), 64'(sch_waddr_w[k]), 64'(nw[k]));
                chk($sformatf("wdata%0d", k), 64'(sch_wdata_w[k]),
                    (nw[k] < exp_idx.size()) ? 64'(exp_idx[nw[k]]) : 64'hFFFF);
                nw[k]++;
            end
        end
    endtask

    // drop < 0: full search; otherwise cs falls at the drop-th falling edge
    task automatic run_search(input int v, input int drop);
        int lim;
        int end_cyc;
        int hi_end;
        int hold_bad;
        int exp_cnt [2];
        bit exp_ovf [2];
        lim = (drop < 0) ? SP_N - 1 : drop - 3;
        if (lim > SP_N - 1) lim = SP_N - 1;
        exp_idx = {};
        for (int i = 0; i <= lim; i++)
            if (ref_hit(v, posy_tab[i])) exp_idx.push_back(i);
        for (int k = 0; k < 2; k++) begin
            exp_cnt[k] = (exp_idx.size() < max_hit(k)) ? exp_idx.size() : max_hit(k);
            exp_ovf[k] = exp_idx.size() > max_hit(k);
            nw[k] = 0;
        end
        late = 0; end_cyc = -1; hi_end = 0; hold_bad = 0;
        @(negedge clk);
        v_count = 10'(v);
        cs = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            sample_writes(c, drop);
            if (drop >= 0) begin
                if (search_end_w[0] || search_end_w[1]) hi_end++;
                if (c == drop) cs = 1'b0;
                if (c == drop + 4) break;
            end else if (search_end_w[0]) begin
                end_cyc = c;
                break;
            end
        end
        if (drop < 0) begin
            chk("latency", 64'(end_cyc), 64'(SP_N + 3));
            chk("end_b", 64'(search_end_w[1]), 64'd1);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                sample_writes(100 + c, drop);
                if (!search_end_w[0] || !search_end_w[1]) hold_bad++;
            end
            chk("end_hold", 64'(hold_bad), 64'd0);
        end else begin
            chk("no_end", 64'(hi_end), 64'd0);
            chk("late_wr", 64'(late), 64'd0);
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("nwr%0d", k), 64'(nw[k]), 64'(exp_cnt[k]));
            chk($sformatf("cnt%0d", k), 64'(search_count_w[k]), 64'(exp_cnt[k]));
            chk($sformatf("ovf%0d", k), 64'(overflow_w[k]), 64'(exp_ovf[k]));
        end
        if (drop < 0) begin
            cs = 1'b0;
            @(negedge clk);
            chk("end_fall", 64'(search_end_w[0] | search_end_w[1]), 64'd0);
            repeat (2) @(negedge clk);
            for (int k = 0; k < 2; k++)
                chk($sformatf("cnt_hold%0d", k), 64'(search_count_w[k]), 64'(exp_cnt[k]));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_end"}, 64'(search_end_w[k]), 64'd0);
            chk({tag, "_cnt"}, 64'(search_count_w[k]), 64'd0);
            chk({tag, "_ovf"}, 64'(overflow_w[k]), 64'd0);
            chk({tag, "_ren"}, 64'(p_ren_w[k]), 64'd0);
            chk({tag, "_addr"}, 64'(p_addr_w[k]), 64'd0);
            chk({tag, "_wen"}, 64'(sch_wen_w[k]), 64'd0);
            chk({tag, "_waddr"}, 64'(sch_waddr_w[k]), 64'd0);
            chk({tag, "_wdata"}, 64'(sch_wdata_w[k]), 64'd0);
        end
    endtask

    initial begin
        int v;
        int drop;
        n_chk = 0; n_err = 0;
        reset = 1'b1; cs = 1'b0; v_count = '0;
        p_data_w[0] = '0; p_data_w[1] = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        reset = 1'b0;

        // Two hits among the first sprites
        posy_tab = '{5, 20, 10, 200, 300, 400, 500, 600};
        load_tab();
        run_search(12, -1);

        // Every sprite below the line
        posy_tab = '{200, 300, 400, 500, 600, 700, 800, 900};
        load_tab();
        run_search(100, -1);

        // Wrap-around sprite at posy 2040
        posy_tab = '{500, 500, 500, 2040, 500, 500, 500, 500};
        load_tab();
        run_search(7, -1);
        run_search(8, -1);
        run_search(0, -1);

        // Four hits overflow the small list
        posy_tab = '{40, 41, 500, 42, 43, 600, 700, 800};
        load_tab();
        run_search(50, -1);
        run_search(50, 4);
        run_search(50, -1);

        // Async reset in the middle of a scan
        @(negedge clk);
        v_count = 10'd50;
        cs = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        cs = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_search(50, -1);

        for (int it = 0; it < 30; it++) begin
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1023);
            for (int i = 0; i < SP_N; i++)
                posy_tab[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2047)
                                                          : (v - $urandom_range(0, 20) + 2048) % 2048;
            load_tab();
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 10) : -1;
            run_search(v, drop);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
